// File: rtl/pong_pkg.sv
// Shared playfield geometry, FSM encoding and helpers for the Pong game controller.
package pong_pkg;

  localparam int unsigned LEFT     = 160;
  localparam int unsigned RIGHT    = 1120;
  localparam int unsigned TOP      = 128;
  localparam int unsigned BOTTOM   = 896;
  localparam int unsigned CENTRE_X = 640;
  localparam int unsigned CENTRE_Y = 512;

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} game_state_t;
  typedef logic [10:0]        coord_t;
  typedef logic signed [11:0] scoord_t;

  // Score increment that holds at the 4-bit ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Free-running divider producing a one-clock game tick every TICK_PERIOD clocks.
module game_tick_gen #(
  parameter int unsigned TICK_PERIOD = 2097152
) (
  input  logic clock,
  input  logic reset_n,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_PERIOD - 1));

  // Tick is high during the cycle the counter sits at 0 after wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_tick <= w_wrap;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, wall/paddle/goal events, scoring and
// the serve/play/point/game-over state machine.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = 2097152,
  parameter int unsigned SERVE_TICKS = 64,
  parameter int unsigned SPEED       = 4,
  parameter int unsigned BALL_R      = 15,
  parameter int unsigned PADDLE_W    = 25,
  parameter int unsigned PADDLE_H    = 125,
  parameter int unsigned P1X         = 225,
  parameter int unsigned P2X         = 1030,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  coord_t      P1y,
  input  coord_t      P2y,
  output coord_t      XDotPosition,
  output coord_t      YDotPosition,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam int unsigned SC_W    = $clog2(SERVE_TICKS + 1);
  localparam scoord_t     R_S     = scoord_t'(BALL_R);
  localparam scoord_t     SPD_S   = scoord_t'(SPEED);
  localparam scoord_t     P1F_S   = scoord_t'(P1X + PADDLE_W);
  localparam scoord_t     P2F_S   = scoord_t'(P2X);
  localparam scoord_t     LEFT_S  = scoord_t'(LEFT);
  localparam scoord_t     RIGHT_S = scoord_t'(RIGHT);
  localparam scoord_t     TOP_S   = scoord_t'(TOP);
  localparam scoord_t     BOT_S   = scoord_t'(BOTTOM);

  game_state_t     r_state, w_state_nxt;
  coord_t          r_x, r_y, w_x_nxt, w_y_nxt;
  logic            r_dx_pos, r_dy_pos, w_dx_nxt, w_dy_nxt;
  logic [3:0]      r_s1, r_s2, w_s1_nxt, w_s2_nxt;
  logic [SC_W-1:0] r_sc, w_sc_nxt;
  logic            r_go;
  logic            w_tick;

  scoord_t     w_x, w_y, w_nx, w_ny;
  logic [11:0] w_yu, w_p1_top, w_p1_bot, w_p2_top, w_p2_bot;
  logic        w_in1, w_in2, w_hit1, w_hit2, w_goal_l, w_goal_r;

  game_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .o_tick (w_tick)
  );

  // Candidate next position and event detection for the current tick.
  assign w_x  = scoord_t'({1'b0, r_x});
  assign w_y  = scoord_t'({1'b0, r_y});
  assign w_nx = r_dx_pos ? w_x + SPD_S : w_x - SPD_S;
  assign w_ny = r_dy_pos ? w_y + SPD_S : w_y - SPD_S;

  // Paddle span checks run unsigned in 12 bits so P1y+PADDLE_H cannot wrap.
  assign w_yu     = {1'b0, r_y};
  assign w_p1_top = {1'b0, P1y};
  assign w_p1_bot = {1'b0, P1y} + 12'(PADDLE_H);
  assign w_p2_top = {1'b0, P2y};
  assign w_p2_bot = {1'b0, P2y} + 12'(PADDLE_H);
  assign w_in1    = (w_yu >= w_p1_top) && (w_yu <= w_p1_bot);
  assign w_in2    = (w_yu >= w_p2_top) && (w_yu <= w_p2_bot);

  assign w_hit1   = !r_dx_pos && (w_x - R_S > P1F_S) && (w_nx - R_S <= P1F_S) && w_in1;
  assign w_hit2   = r_dx_pos && (w_x + R_S < P2F_S) && (w_nx + R_S >= P2F_S) && w_in2;
  assign w_goal_l = !w_hit1 && !w_hit2 && (w_nx - R_S <= LEFT_S);
  assign w_goal_r = !w_hit1 && !w_hit2 && !w_goal_l && (w_nx + R_S >= RIGHT_S);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_x      <= coord_t'(CENTRE_X);
      r_y      <= coord_t'(CENTRE_Y);
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b1;
      r_s1     <= '0;
      r_s2     <= '0;
      r_sc     <= '0;
      r_go     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_dx_pos <= w_dx_nxt;
      r_dy_pos <= w_dy_nxt;
      r_s1     <= w_s1_nxt;
      r_s2     <= w_s2_nxt;
      r_sc     <= w_sc_nxt;
      r_go     <= (w_state_nxt == OVER);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dx_nxt    = r_dx_pos;
    w_dy_nxt    = r_dy_pos;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_sc_nxt    = r_sc;
    case (r_state)
      IDLE: begin
        w_x_nxt = coord_t'(CENTRE_X);
        w_y_nxt = coord_t'(CENTRE_Y);
        if (start) begin
          w_state_nxt = SERVE;
          w_sc_nxt    = '0;
        end
      end
      SERVE: begin
        w_x_nxt = coord_t'(CENTRE_X);
        w_y_nxt = coord_t'(CENTRE_Y);
        if (w_tick) begin
          w_sc_nxt = r_sc + SC_W'(1);
          if (r_sc == SC_W'(SERVE_TICKS - 1)) w_state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (w_tick) begin
          // Wall bounce and paddle/goal resolve independently on the same tick.
          w_y_nxt = w_ny[10:0];
          if (r_dy_pos && (w_ny + R_S >= BOT_S)) begin
            w_y_nxt  = coord_t'(BOTTOM - BALL_R);
            w_dy_nxt = 1'b0;
          end else if (!r_dy_pos && (w_ny - R_S <= TOP_S)) begin
            w_y_nxt  = coord_t'(TOP + BALL_R);
            w_dy_nxt = 1'b1;
          end
          w_x_nxt = w_nx[10:0];
          if (w_hit1) begin
            w_x_nxt  = coord_t'(P1X + PADDLE_W + BALL_R);
            w_dx_nxt = 1'b1;
          end else if (w_hit2) begin
            w_x_nxt  = coord_t'(P2X - BALL_R);
            w_dx_nxt = 1'b0;
          end else if (w_goal_l) begin
            w_s2_nxt    = sat_inc(r_s2);
            w_dx_nxt    = 1'b0;
            w_state_nxt = POINT;
          end else if (w_goal_r) begin
            w_s1_nxt    = sat_inc(r_s1);
            w_dx_nxt    = 1'b1;
            w_state_nxt = POINT;
          end
        end
      end
      POINT: begin
        w_x_nxt = coord_t'(CENTRE_X);
        w_y_nxt = coord_t'(CENTRE_Y);
        if ((r_s1 == 4'(WIN_SCORE)) || (r_s2 == 4'(WIN_SCORE))) begin
          w_state_nxt = OVER;
        end else begin
          w_state_nxt = SERVE;
          w_sc_nxt    = '0;
        end
      end
      OVER: begin
        w_x_nxt = coord_t'(CENTRE_X);
        w_y_nxt = coord_t'(CENTRE_Y);
        if (start) begin
          w_s1_nxt    = '0;
          w_s2_nxt    = '0;
          w_sc_nxt    = '0;
          w_state_nxt = SERVE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign XDotPosition = r_x;
  assign YDotPosition = r_y;
  assign score1       = r_s1;
  assign score2       = r_s2;
  assign game_over    = r_go;
  assign state        = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: scripted vectors, game-play scenarios and random
// play checked every cycle against an integer model of the game rules.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int TP  = 4;
  localparam int ST  = 2;
  localparam int SPD = 4;
  localparam int BR  = 15;
  localparam int PH  = 125;
  localparam int P1F = 225 + 25;
  localparam int P2F = 1030;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] P1y, P2y;
  logic [10:0] XDotPosition, YDotPosition;
  logic [3:0]  score1, score2;
  logic        game_over;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers).
  int          m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_sc, m_edges, m_loser;
  game_state_t m_state;

  pong_game_ctrl #(
    .TICK_PERIOD(TP), .SERVE_TICKS(ST), .SPEED(SPD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .P1y(P1y), .P2y(P2y),
    .XDotPosition(XDotPosition), .YDotPosition(YDotPosition),
    .score1(score1), .score2(score2), .game_over(game_over), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic st;
    int   n;
    int   ex, ey, es, es1, es2, ego;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 640; m_y = 512; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_sc = 0; m_edges = 0; m_loser = 0;
    m_state = IDLE;
  endtask

  function automatic int sat15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // One clock edge of the game rules, using the inputs present at the edge.
  task automatic model_edge();
    bit tk;
    int nx, ny, oy;
    bit h1, h2;
    tk = (m_edges % TP == 0) && (m_edges > 0);
    m_edges++;
    case (m_state)
      IDLE: if (start) begin m_state = SERVE; m_sc = 0; end
      SERVE: if (tk) begin
        m_sc++;
        if (m_sc == ST) m_state = PLAY;
      end
      PLAY: if (tk) begin
        oy = m_y;
        nx = m_x + m_dx * SPD;
        ny = m_y + m_dy * SPD;
        if (m_dy > 0 && ny + BR >= 896) begin m_y = 896 - BR; m_dy = -1; end
        else if (m_dy < 0 && ny - BR <= 128) begin m_y = 128 + BR; m_dy = 1; end
        else m_y = ny;
        h1 = (m_dx < 0) && (m_x - BR > P1F) && (nx - BR <= P1F) &&
             (int'(P1y) <= oy) && (oy <= int'(P1y) + PH);
        h2 = (m_dx > 0) && (m_x + BR < P2F) && (nx + BR >= P2F) &&
             (int'(P2y) <= oy) && (oy <= int'(P2y) + PH);
        if (h1) begin m_x = P1F + BR; m_dx = 1; end
        else if (h2) begin m_x = P2F - BR; m_dx = -1; end
        else begin
          m_x = nx;
          if (nx - BR <= 160) begin m_s2 = sat15(m_s2); m_loser = 1; m_state = POINT; end
          else if (nx + BR >= 1120) begin m_s1 = sat15(m_s1); m_loser = 2; m_state = POINT; end
        end
      end
      POINT: begin
        m_x = 640; m_y = 512;
        if (m_s1 == 7 || m_s2 == 7) m_state = OVER;
        else begin
          m_state = SERVE; m_sc = 0;
          m_dx = (m_loser == 1) ? -1 : 1;
        end
      end
      OVER: if (start) begin
        m_s1 = 0; m_s2 = 0; m_sc = 0; m_state = SERVE;
      end
      default: m_state = IDLE;
    endcase
    if (m_state inside {IDLE, SERVE, OVER}) begin m_x = 640; m_y = 512; end
  endtask

  task automatic cmp_model();
    chk("model_x", int'(XDotPosition), m_x);
    chk("model_y", int'(YDotPosition), m_y);
    chk("model_s1", int'(score1), m_s1);
    chk("model_s2", int'(score2), m_s2);
    chk("model_go", int'(game_over), int'(m_state == OVER));
    chk("model_state", int'(state), int'(m_state));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, int'(XDotPosition), 640);
    chk({tag, "_y"}, int'(YDotPosition), 512);
    chk({tag, "_s1"}, int'(score1), 0);
    chk({tag, "_s2"}, int'(score2), 0);
    chk({tag, "_go"}, int'(game_over), 0);
    chk({tag, "_state"}, int'(state), int'(IDLE));
  endtask

  function automatic logic [10:0] near(input int y);
    int t;
    t = y - int'($urandom_range(0, 130));
    if (t < 0) t = 0;
    return 11'(t);
  endfunction

  initial begin
    tbl[0] = '{st: 1'b0, n: 1, ex: 640, ey: 512, es: int'(IDLE),  es1: 0, es2: 0, ego: 0};
    tbl[1] = '{st: 1'b1, n: 1, ex: 640, ey: 512, es: int'(SERVE), es1: 0, es2: 0, ego: 0};
    tbl[2] = '{st: 1'b0, n: 6, ex: 640, ey: 512, es: int'(SERVE), es1: 0, es2: 0, ego: 0};
    tbl[3] = '{st: 1'b0, n: 1, ex: 640, ey: 512, es: int'(PLAY),  es1: 0, es2: 0, ego: 0};
    tbl[4] = '{st: 1'b0, n: 3, ex: 640, ey: 512, es: int'(PLAY),  es1: 0, es2: 0, ego: 0};
    tbl[5] = '{st: 1'b0, n: 1, ex: 644, ey: 516, es: int'(PLAY),  es1: 0, es2: 0, ego: 0};
    tbl[6] = '{st: 1'b0, n: 4, ex: 648, ey: 520, es: int'(PLAY),  es1: 0, es2: 0, ego: 0};

    reset_n = 1'b0; start = 1'b0; P1y = 11'd800; P2y = 11'd800;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    model_reset();

    // Serve sequencing and first motion steps.
    for (int i = 0; i < 7; i++) begin
      start = tbl[i].st;
      repeat (tbl[i].n) cyc();
      chk($sformatf("tbl%0d_x", i), int'(XDotPosition), tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), int'(YDotPosition), tbl[i].ey);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].es);
      chk($sformatf("tbl%0d_s1", i), int'(score1), tbl[i].es1);
      chk($sformatf("tbl%0d_s2", i), int'(score2), tbl[i].es2);
      chk($sformatf("tbl%0d_go", i), int'(game_over), tbl[i].ego);
    end
    start = 1'b0;

    // Bottom wall bounce, then right paddle return (paddle 2 spans 800..925).
    for (int k = 0; k < 2000 && m_y != 880; k++) cyc();
    chk("bottom_reach", int'(YDotPosition), 880);
    repeat (TP) cyc();
    chk("bottom_clamp", int'(YDotPosition), 881);
    repeat (TP) cyc();
    chk("bottom_rebound", int'(YDotPosition), 877);
    chk("p2_hit_x", int'(XDotPosition), 1015);

    // Left paddle placed under the ball: clamp to its face and reverse.
    for (int k = 0; k < 4000 && m_dx < 0; k++) begin
      P1y = 11'(m_y - 40);
      cyc();
    end
    chk("p1_hit_x", int'(XDotPosition), 265);
    chk("p1_hit_s1", int'(score1), 0);
    chk("p1_hit_s2", int'(score2), 0);

    // Right paddle returns, left paddle misses: point to player 2.
    for (int k = 0; k < 6000 && m_state != POINT; k++) begin
      P2y = 11'(m_y - 40);
      P1y = 11'(m_y + 1);
      cyc();
    end
    chk("miss_state", int'(state), int'(POINT));
    chk("miss_s2", int'(score2), 1);
    chk("miss_s1", int'(score1), 0);
    cyc();
    chk("point_to_serve", int'(state), int'(SERVE));
    chk("serve_x", int'(XDotPosition), 640);
    chk("serve_y", int'(YDotPosition), 512);
    for (int k = 0; k < 200 && m_x == 640; k++) cyc();
    chk("serve_dx_left", int'(XDotPosition), 636);

    // Player 2 keeps missing until player 1 reaches the winning score.
    for (int k = 0; k < 30000 && !(m_state == POINT && m_s1 == 7); k++) begin
      P1y = 11'(m_y - 40);
      P2y = 11'(m_y + 1);
      cyc();
    end
    chk("win_s1", int'(score1), 7);
    cyc();
    chk("over_state", int'(state), int'(OVER));
    chk("over_go", int'(game_over), 1);
    cyc();
    chk("over_hold", int'(state), int'(OVER));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", int'(state), int'(SERVE));
    chk("restart_go", int'(game_over), 0);
    chk("restart_s1", int'(score1), 0);
    chk("restart_s2", int'(score2), 0);

    // Randomised play: paddles sometimes track the ball, sometimes anywhere.
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom_range(0, 7) == 0);
      P1y = ($urandom_range(0, 3) == 0) ? 11'($urandom) : near(m_y);
      P2y = ($urandom_range(0, 3) == 0) ? 11'($urandom) : near(m_y);
      cyc();
    end

    // Asynchronous reset while the ball is moving.
    for (int k = 0; k < 3000 && !(m_state == PLAY && m_x != 640); k++) begin
      start = 1'b1;
      P1y = near(m_y);
      P2y = near(m_y);
      cyc();
    end
    start = 1'b0;
    chk("pre_rst_play", int'(state), int'(PLAY));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
